// File: rtl/regfile_alu_unit.sv
// Register-file calculator: edge-detected write/exec requests, a small sequencer
// and a registered double-width ALU result. Optional macro: REGFILE_WRITEBACK_EN.
module regfile_alu_unit #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_req,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 exec_req,
  input  logic [AW-1:0]        raddr1,
  input  logic [AW-1:0]        raddr2,
  input  logic [2:0]           op_sel,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_valid,
  output logic                 carry,
  output logic                 zero,
  output logic                 busy
);
  localparam int             W2      = 2 * WIDTH;
  localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_CAPT, S_EXEC, S_WB, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               wr_hist_q, ex_hist_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic [W2-1:0]      result_q;
  logic               carry_q, zero_q;
`ifdef REGFILE_WRITEBACK_EN
  logic [AW-1:0]      ra1_q;
`endif

  logic               wr_edge, ex_edge;
  logic [WIDTH-1:0]   rd_a, rd_b;
  logic [W2-1:0]      a_ext, b_ext, alu_res;
  logic               alu_c;

  // History resets to 1 so a request held through reset release never fires.
  assign wr_edge = wr_req & ~wr_hist_q;
  assign ex_edge = exec_req & ~ex_hist_q;

  assign rd_a  = ({1'b0, raddr1} < DEPTH_W) ? mem_q[raddr1] : '0;
  assign rd_b  = ({1'b0, raddr2} < DEPTH_W) ? mem_q[raddr2] : '0;
  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign b_ext = {{WIDTH{1'b0}}, b_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ex_edge) state_d = S_CAPT;
      S_CAPT: state_d = S_EXEC;
`ifdef REGFILE_WRITEBACK_EN
      S_EXEC: state_d = S_WB;
`else
      S_EXEC: state_d = S_DONE;
`endif
      S_WB:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      3'b000: begin alu_res = a_ext + b_ext; alu_c = alu_res[WIDTH]; end
      3'b001: begin alu_res = b_ext - a_ext; alu_c = (a_q > b_q); end
      3'b010: alu_res = {b_q, a_q};
      3'b011: alu_res = a_ext & b_ext;
      3'b100: alu_res = a_ext | b_ext;
      3'b101: alu_res = a_ext ^ b_ext;
      3'b110: alu_res = a_ext * b_ext;
      default: alu_res = a_ext;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_hist_q <= 1'b1;
      ex_hist_q <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
`ifdef REGFILE_WRITEBACK_EN
      ra1_q     <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_hist_q <= wr_req;
      ex_hist_q <= exec_req;
      // Write lands on the accepting edge, so a coincident exec reads it in CAPT.
      if (state_q == S_IDLE && wr_edge && ({1'b0, waddr} < DEPTH_W))
        mem_q[waddr] <= wdata;
`ifdef REGFILE_WRITEBACK_EN
      if (state_q == S_WB && ({1'b0, ra1_q} < DEPTH_W))
        mem_q[ra1_q] <= result_q[WIDTH-1:0];
`endif
      if (state_q == S_CAPT) begin
        a_q  <= rd_a;
        b_q  <= rd_b;
        op_q <= op_sel;
`ifdef REGFILE_WRITEBACK_EN
        ra1_q <= raddr1;
`endif
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_res;
        carry_q  <= alu_c;
        zero_q   <= (alu_res == '0);
      end
    end
  end

  assign result       = result_q;
  assign carry        = carry_q;
  assign zero         = zero_q;
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
endmodule
